// File: rtl/int_log_if.sv
// Start/done handshake bundle for the integer logarithm block.
interface int_log_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    modport master (
        output start, base, value,
        input  busy, done, result, error
    );

    modport slave (
        input  start, base, value,
        output busy, done, result, error
    );
endinterface

// File: rtl/int_log.sv
// Sequential floor(log_base(value)): one multiply per clock until the product exceeds value.
module int_log #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    int_log_if.slave   bus
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_base, w_base_nxt;
    logic [WIDTH-1:0] r_value, w_value_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_error, w_error_nxt;
    logic [PW-1:0]    w_prod;

    // Full-width product; acc never exceeds value, so it cannot overflow PW bits.
    assign w_prod = PW'(r_acc) * PW'(r_base);

    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_value_nxt  = r_value;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_error_nxt  = r_error;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_base_nxt  = bus.base;
                    w_value_nxt = bus.value;
                    if ((bus.base < WIDTH'(2)) || (bus.value == '0)) begin
                        w_done_nxt   = 1'b1;
                        w_error_nxt  = 1'b1;
                        w_result_nxt = '0;
                        w_busy_nxt   = 1'b0;
                    end else begin
                        w_acc_nxt   = WIDTH'(1);
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_error_nxt = 1'b0;
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (w_prod <= PW'(r_value)) begin
                    w_acc_nxt = w_prod[WIDTH-1:0];
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end else begin
                    w_result_nxt = r_cnt;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_value  <= '0;
            r_acc    <= WIDTH'(1);
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_base   <= w_base_nxt;
            r_value  <= w_value_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_error  <= w_error_nxt;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.error  = r_error;
endmodule

// File: tb/tb_int_log.sv
// Directed bench for int_log: transaction-level model checked every cycle plus literal expectations.
module tb_int_log;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    int_log_if #(.WIDTH(WIDTH)) bus ();
    int_log #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Plain arithmetic: largest k with b^k <= v (b >= 2, v >= 1).
    function automatic int flog(input int b, input int v);
        int k = 0;
        longint p = longint'(b);
        while (p <= longint'(v)) begin
            k++;
            p = p * longint'(b);
        end
        return k;
    endfunction

    // Model: a request occupies the block for L+1 cycles, then done reports L.
    int m_remain = 0;
    int m_pending = 0;
    int m_result = 0;
    bit m_done = 1'b0;
    bit m_error = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_remain = 0; m_pending = 0; m_result = 0; m_done = 1'b0; m_error = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_done = 1'b1;
                    m_result = m_pending;
                end
            end else if (bus.start) begin
                if (int'(bus.base) < 2 || int'(bus.value) == 0) begin
                    m_done = 1'b1; m_error = 1'b1; m_result = 0;
                end else begin
                    m_pending = flog(int'(bus.base), int'(bus.value));
                    m_remain = m_pending + 1;
                    m_error = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(bus.busy), int'(m_remain > 0));
        chk("done", int'(bus.done), int'(m_done));
        chk("result", int'(bus.result), m_result);
        chk("error", int'(bus.error), int'(m_error));
        chk("busy_done_excl", int'(bus.busy && bus.done), 0);
    end

    // Called just after the start-sampling edge; counts edges until done is seen.
    task automatic wait_done(output int cyc, output bit seen);
        cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input string nm, input int b, input int v,
                       input int exp_r, input int exp_e, input int exp_lat);
        int cyc;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.base = WIDTH'(b); bus.value = WIDTH'(v);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(cyc, seen);
        if (seen) begin
            chk({nm, "_latency"}, cyc, exp_lat);
            chk({nm, "_result"}, int'(bus.result), exp_r);
            chk({nm, "_error"}, int'(bus.error), exp_e);
        end
    endtask

    initial begin
        int cyc;
        bit seen;
        bus.start = 1'b0; bus.base = '0; bus.value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_result", int'(bus.result), 0);
        @(negedge clk) rst_n = 1'b1;

        run("b3_v81", 3, 81, 4, 0, 5);
        run("b3_v80", 3, 80, 3, 0, 4);
        run("b255_v255", 255, 255, 1, 0, 2);
        run("b2_v1", 2, 1, 0, 0, 1);
        run("b2_v255", 2, 255, 7, 0, 8);
        run("b1_v10", 1, 10, 0, 1, 0);
        run("b0_v5", 0, 5, 0, 1, 0);
        run("b5_v0", 5, 0, 0, 1, 0);
        run("b10_v99", 10, 99, 1, 0, 2);

        // Start while busy is ignored; operand changes while busy have no effect.
        @(negedge clk);
        bus.start = 1'b1; bus.base = 8'd2; bus.value = 8'd200;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.base = 8'd10; bus.value = 8'd10;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.base = 8'd77; bus.value = 8'd3;
        wait_done(cyc, seen);
        if (seen) begin
            chk("ignored_start_result", int'(bus.result), 7);
            // Start in the done cycle is accepted without a dead cycle.
            bus.start = 1'b1; bus.base = 8'd10; bus.value = 8'd100;
            @(posedge clk);
            #1 bus.start = 1'b0;
            wait_done(cyc, seen);
            if (seen) begin
                chk("b2b_latency", cyc, 3);
                chk("b2b_result", int'(bus.result), 2);
                chk("b2b_error", int'(bus.error), 0);
            end
        end

        // Asynchronous reset mid-computation.
        @(negedge clk);
        bus.start = 1'b1; bus.base = 8'd2; bus.value = 8'd255;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_result", int'(bus.result), 0);
        chk("midrst_error", int'(bus.error), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        run("post_rst_b5_v125", 5, 125, 3, 0, 4);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/int_log.md
Name: int_log

Overview:
- Sequential inverse of the exponentiation block: given base and value, computes floor(log_base(value)), the largest k with base^k <= value.
- Iterates one multiply per clock, with a start/done handshake.
- Sits beside the exponentiation datapath for round-trip checks and exponent recovery.

Parameters:
WIDTH, 8, bit width of base, value and result

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only when idle
base  input  WIDTH  logarithm base, unsigned
value  input  WIDTH  operand, unsigned
busy  output  1  high while a computation is in progress
done  output  1  one-cycle pulse; result and error valid
result  output  WIDTH  floor(log_base(value)); held until next done
error  output  1  invalid operands flag; valid with done, held until next done

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset:
  - State goes to IDLE immediately on rst_n low, regardless of clock.
  - busy, done, result and error are all cleared to 0.
  - Internal acc is cleared to 1 and cnt to 0.
- States are IDLE and CALC.
- IDLE:
  - On a clk edge with start=1, latch base and value into internal registers.
  - If base<2 or value==0: next edge state stays IDLE; done=1, error=1, result=0, busy=0. There is no CALC cycle.
  - Otherwise: acc<=1 (WIDTH bits), cnt<=0, busy<=1, error<=0, state<=CALC.
- CALC, on each edge:
  - prod = acc*base, computed at 2*WIDTH bits with no truncation. acc<=value<2^WIDTH, so prod never overflows.
  - If prod <= value: acc<=prod[WIDTH-1:0], cnt<=cnt+1, stay in CALC.
  - Else: result<=cnt, done<=1, busy<=0, state<=IDLE.
- Latency:
  - Start sampled at edge T with L = final result: done is high in the cycle after edge T+L+1, and busy is high for L+1 cycles.
  - Error case: done after edge T.
- done is a single-cycle pulse and deasserts on the following edge.
- busy and done are never high together.
- start while busy=1 is ignored. It is not queued, and latched operands are unaffected.
- Input changes on base/value while busy have no effect.
- start during the done cycle (state already IDLE) is accepted. Back-to-back operation therefore has no dead cycle.
- result and error are held between done pulses.
- Maximum result is WIDTH-1 (base 2, value 2^WIDTH-1), so the counter never wraps.
- rst_n asserted mid-CALC:
  - Computation is aborted and no done is issued.
  - After release, the block is idle with outputs 0.

Test Plan:
- base=3, value=81, start at edge T -> busy high for 5 cycles; done after edge T+5; result=4, error=0.
- base=3, value=80 -> result=3 after edge T+4. Then base=255, value=255 -> result=1. Then base=2, value=1 -> result=0, done after T+1.
- base=2, value=255 (WIDTH=8) -> result=7, done after edge T+8, no counter/product overflow.
- base=1, value=10 -> done after edge T, error=1, result=0, busy never high. Repeat with base=0, value=5 and with base=5, value=0 -> same response.
- Protocol/timing:
  - Start base=2, value=200. Re-pulse start with base=10, value=10 while busy -> ignored; result=7.
  - Assert start again in the done cycle with base=10, value=100 -> accepted; result=2.
- Mid-CALC reset:
  - Start base=2, value=255; drop rst_n asynchronously (between edges) at cycle 3 -> outputs 0 immediately, no done pulse.
  - After release, base=5, value=125 -> result=3.
